ram_2p_arbiter: RTL



---
 rtl/ibex_pkg.sv | 14 +
 rtl/ram_arb_rr_pick.sv | 36 +++
 rtl/ram_2p_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types and limits for the two-port RAM arbiter.
package ibex_pkg;

   localparam int unsigned RamArbMaxReq = 8;

   // One requester's transaction at the default 32-bit data width.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } ram_arb_req_t;

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or after ptr_i, wrapping.
module ram_arb_rr_pick
   import ibex_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned Iw = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [Iw-1:0] ptr_i,
   output logic          valid_o,
   output logic [Iw-1:0] idx_o
);

   logic [Iw-1:0] sel;
   int            j;

   // Scan from the farthest candidate back to ptr_i so the nearest requester wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      sel     = '0;
      j       = 0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= int'(N)) begin
            j = j - int'(N);
         end
         sel = Iw'(j);
         if (req_i[sel]) begin
            valid_o = 1'b1;
            idx_o   = sel;
         end
      end
   end

endmodule

// File: rtl/ram_2p_arbiter.sv
// Round-robin arbiter giving up to two requesters per cycle access to a shared two-port RAM.
// Optional same-address hazard deferral and conflict_o output: `define RAM_ARB_CONFLICT_CHECK_EN.
module ram_2p_arbiter
   import ibex_pkg::*;
#(
   parameter  int unsigned NumReq = 4,
   parameter  int unsigned Width  = 32,
   parameter  int unsigned Depth  = 128,
   localparam int unsigned Aw     = $clog2(Depth),
   localparam int unsigned Bw     = Width / 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumReq-1:0]            req_i,
   input  logic [NumReq-1:0]            we_i,
   input  logic [NumReq-1:0][Aw-1:0]    addr_i,
   input  logic [NumReq-1:0][Width-1:0] wdata_i,
   input  logic [NumReq-1:0][Bw-1:0]    be_i,
   output logic [NumReq-1:0]            gnt_o,
   output logic [NumReq-1:0]            rvalid_o,
   output logic [NumReq-1:0][Width-1:0] rdata_o,
`ifdef RAM_ARB_CONFLICT_CHECK_EN
   output logic                         conflict_o,
`endif
   output logic                         a_req_o,
   output logic                         a_write_o,
   output logic [Aw-1:0]                a_addr_o,
   output logic [Width-1:0]             a_wdata_o,
   output logic [Width-1:0]             a_wmask_o,
   input  logic [Width-1:0]             a_rdata_i,
   output logic                         b_req_o,
   output logic                         b_write_o,
   output logic [Aw-1:0]                b_addr_o,
   output logic [Width-1:0]             b_wdata_o,
   output logic [Width-1:0]             b_wmask_o,
   input  logic [Width-1:0]             b_rdata_i
);

   localparam int unsigned Iw = $clog2(NumReq);

   if ((NumReq < 2) || (NumReq > RamArbMaxReq) || ((Width % 8) != 0)) begin : gen_param_check
      $error("ram_2p_arbiter: NumReq must be 2..8 and Width a multiple of 8");
   end

   logic [Iw-1:0]                ptr_q, ptr_d;
   logic [NumReq-1:0]            rvalid_q;
   logic [NumReq-1:0][Width-1:0] rdata_q, rdata_d;

   logic                         pickAValid, pickBValid;
   logic [Iw-1:0]                pickAIdx, pickBIdx, startB;
   logic [NumReq-1:0]            reqMaskedB;
   logic                         sameAddrHazard;
   logic                         grantA, grantB;

   function automatic logic [Iw-1:0] nextIdx(input logic [Iw-1:0] idx);
      return (idx == Iw'(NumReq - 1)) ? '0 : idx + 1'b1;
   endfunction

   ram_arb_rr_pick #(.N(NumReq)) u_pick_a (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .valid_o (pickAValid),
      .idx_o   (pickAIdx)
   );

   // Pick B continues the scan just past pick A, with pick A removed.
   always_comb begin
      reqMaskedB           = req_i;
      reqMaskedB[pickAIdx] = 1'b0;
   end

   assign startB = nextIdx(pickAIdx);

   ram_arb_rr_pick #(.N(NumReq)) u_pick_b (
      .req_i   (reqMaskedB),
      .ptr_i   (startB),
      .valid_o (pickBValid),
      .idx_o   (pickBIdx)
   );

`ifdef RAM_ARB_CONFLICT_CHECK_EN
   assign sameAddrHazard = pickAValid && pickBValid &&
                           (addr_i[pickAIdx] == addr_i[pickBIdx]) &&
                           (we_i[pickAIdx] || we_i[pickBIdx]);
`else
   assign sameAddrHazard = 1'b0;
`endif

   assign grantA = pickAValid && !rst_i;
   assign grantB = pickBValid && !sameAddrHazard && !rst_i;

   always_comb begin
      gnt_o = '0;
      if (grantA) gnt_o[pickAIdx] = 1'b1;
      if (grantB) gnt_o[pickBIdx] = 1'b1;
   end

   // Idle ports, and write data/mask on reads, are driven to zero.
   always_comb begin
      a_req_o   = grantA;
      a_write_o = 1'b0;
      a_addr_o  = '0;
      a_wdata_o = '0;
      a_wmask_o = '0;
      b_req_o   = grantB;
      b_write_o = 1'b0;
      b_addr_o  = '0;
      b_wdata_o = '0;
      b_wmask_o = '0;
      if (grantA) begin
         a_write_o = we_i[pickAIdx];
         a_addr_o  = addr_i[pickAIdx];
         if (we_i[pickAIdx]) begin
            a_wdata_o = wdata_i[pickAIdx];
            for (int b = 0; b < int'(Bw); b++) begin
               a_wmask_o[8*b +: 8] = {8{be_i[pickAIdx][b]}};
            end
         end
      end
      if (grantB) begin
         b_write_o = we_i[pickBIdx];
         b_addr_o  = addr_i[pickBIdx];
         if (we_i[pickBIdx]) begin
            b_wdata_o = wdata_i[pickBIdx];
            for (int b = 0; b < int'(Bw); b++) begin
               b_wmask_o[8*b +: 8] = {8{be_i[pickBIdx][b]}};
            end
         end
      end
   end

   // Writes answer with zero; ungranted requesters keep their last response data.
   always_comb begin
      rdata_d = rdata_q;
      if (grantA) rdata_d[pickAIdx] = we_i[pickAIdx] ? '0 : a_rdata_i;
      if (grantB) rdata_d[pickBIdx] = we_i[pickBIdx] ? '0 : b_rdata_i;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grantB) begin
         ptr_d = nextIdx(pickBIdx);
      end else if (grantA) begin
         ptr_d = nextIdx(pickAIdx);
      end
   end

`ifdef RAM_ARB_CONFLICT_CHECK_EN
   logic conflict_q;
   assign conflict_o = conflict_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
`ifdef RAM_ARB_CONFLICT_CHECK_EN
         conflict_q <= 1'b0;
`endif
      end else begin
         ptr_q    <= ptr_d;
         rvalid_q <= gnt_o;
         rdata_q  <= rdata_d;
`ifdef RAM_ARB_CONFLICT_CHECK_EN
         conflict_q <= sameAddrHazard;
`endif
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

endmodule
